// File: rtl/mem_bus_if.sv
// mem_bus_if: turns multicycle-controller memory strobes into a held
// request/acknowledge transaction and captures read data into the
// instruction or data register, stalling the controller meanwhile.
// Optional build macro: MEM_BUS_IF_TIMEOUT_EN adds a BUSY wait counter that
// abandons a transaction after TIMEOUT_CYCLES and raises a sticky err.
module mem_bus_if #(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] adr,
    input  logic [DATA_W-1:0] writedata,
    input  logic              memread,
    input  logic              memwrite,
    input  logic              irwrite,
    output logic              stall,
    output logic [DATA_W-1:0] instr,
    output logic [DATA_W-1:0] data,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state, state_d;
    logic              req_d, we_d, cap_ir, cap_ir_d;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] wdata_d, instr_d, data_d;
    logic              timeout_c;

    // A zero timeout would abandon every transaction before it could complete
    if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
        $error("mem_bus_if: TIMEOUT_CYCLES must be non-zero");
    end

`ifdef MEM_BUS_IF_TIMEOUT_EN
    localparam int unsigned CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ?
                                    $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [CNT_W-1:0] cnt;

    // Wait counter: counts BUSY cycles, cleared everywhere else
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)              cnt <= '0;
        else if (state == BUSY)  cnt <= cnt + CNT_W'(1);
        else                     cnt <= '0;
    end

    assign timeout_c = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Sticky error: set when BUSY gives up without an ack
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                                    err <= 1'b0;
        else if ((state == BUSY) && !mem_ack && timeout_c) err <= 1'b1;
    end
`else
    assign timeout_c = 1'b0;
    assign err       = 1'b0;
`endif

    // Controller freeze: request being accepted, or transaction outstanding
    assign stall = ((state == IDLE) && (memread || memwrite)) || (state == BUSY);

    // State and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cap_ir    <= 1'b0;
            instr     <= '0;
            data      <= '0;
        end else begin
            state     <= state_d;
            mem_req   <= req_d;
            mem_we    <= we_d;
            mem_addr  <= addr_d;
            mem_wdata <= wdata_d;
            cap_ir    <= cap_ir_d;
            instr     <= instr_d;
            data      <= data_d;
        end
    end

    // Next state and next register values
    always_comb begin
        state_d  = state;
        req_d    = mem_req;
        we_d     = mem_we;
        addr_d   = mem_addr;
        wdata_d  = mem_wdata;
        cap_ir_d = cap_ir;
        instr_d  = instr;
        data_d   = data;
        unique case (state)
            IDLE: begin
                if (memread || memwrite) begin
                    state_d  = BUSY;
                    req_d    = 1'b1;
                    we_d     = memwrite;
                    addr_d   = adr;
                    wdata_d  = writedata;
                    cap_ir_d = irwrite && !memwrite;
                end
            end
            BUSY: begin
                if (mem_ack) begin
                    state_d = DONE;
                    req_d   = 1'b0;
                    if (!mem_we) begin
                        if (cap_ir) instr_d = mem_rdata;
                        else        data_d  = mem_rdata;
                    end
                end else if (timeout_c) begin
                    state_d = DONE;
                    req_d   = 1'b0;
                end
            end
            DONE: begin
                // Controller is still in the requesting state; ignore strobes
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

endmodule

// File: doc/mem_bus_if.md
# mem_bus_if

Multicycle-core memory interface sitting directly downstream of the controller's memory strobes and address mux. It turns per-state `memread`/`memwrite`/`irwrite` strobes into a held request/acknowledge transaction on an external memory port. It stalls the controller FSM until the memory acknowledges, then captures returned data into the instruction register or the data register.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `TIMEOUT_CYCLES`, 255, maximum wait for `mem_ack`; used only with the timeout feature compiled in
- `clk` in 1 — single clock; all state changes on its rising edge
- `reset` in 1 — asynchronous, active-low reset
- `adr` in ADDR_W — address from the datapath address mux
- `writedata` in DATA_W — store data
- `memread` in 1 — read strobe: fetch and lw states
- `memwrite` in 1 — write strobe from the controller
- `irwrite` in 1 — read data is an instruction
- `stall` out 1 — freeze the controller state register and all datapath enables
- `instr` out DATA_W — instruction register
- `data` out DATA_W — data register
- `mem_req` out 1, `mem_we` out 1, `mem_addr` out ADDR_W, `mem_wdata` out DATA_W — external request
- `mem_ack` in 1, `mem_rdata` in DATA_W — external response; `mem_rdata` is valid in the `mem_ack` cycle
- `err` out 1 — sticky timeout flag

## Operation
- FSM states: IDLE, BUSY, DONE. Reset state is IDLE.
- Reset values: `mem_req`/`mem_we`/`stall`/`err` = 0; `mem_addr`/`mem_wdata`/`instr`/`data` = 0.
- IDLE → BUSY when `memread | memwrite`:
  - Latch `adr`, `writedata`, `mem_we = memwrite`, `cap_ir = irwrite & ~memwrite`.
  - Set `mem_req` for the next cycle.
- Priority: `memwrite` beats `memread` when both are high. Only a write is issued, and no register is updated.
- BUSY:
  - `mem_req` and the latched address, data and `we` are held stable until `mem_ack` is sampled high.
  - On ack, a read loads `mem_rdata` into `instr` if `cap_ir`, else into `data`. A write updates neither register.
  - On ack, `mem_req` drops and the next state is DONE.
- DONE lasts exactly one cycle, then IDLE unconditionally. Strobes during DONE are ignored: the controller is still in the same state that made the request.
- `stall` is combinational: `(IDLE & (memread | memwrite)) | BUSY`. It is 0 in DONE.
- `irwrite` without `memread` is ignored.
- `mem_ack` while in IDLE or DONE is ignored.
- `instr` and `data` are unchanged except by a completed read.

## Timing
- Request seen in IDLE at cycle t:
  - `stall` = 1 in cycle t.
  - `mem_req` = 1 from t+1.
- `mem_ack` at t+k (k ≥ 1):
  - Register loaded at the t+k edge and visible from t+k+1.
  - DONE in t+k+1, with `stall` = 0 there.
- Minimum stall is 2 cycles per access.
- Back-to-back accesses: the next request is accepted in the first IDLE cycle after DONE.
- Reset asserted mid-transaction: `mem_req` drops asynchronously and all registers clear. The memory must tolerate an abandoned request. A late `mem_ack` after reset release is ignored in IDLE.

## Configuration
- `MEM_BUS_IF_TIMEOUT_EN` defined:
  - An 8-bit-or-wider wait counter runs in BUSY.
  - After `TIMEOUT_CYCLES` cycles without ack: drop `mem_req`, set `err` (sticky until reset), go to DONE with no register update.
- Undefined: BUSY waits indefinitely; `err` is tied 0; no counter is present.

## Test plan
- Fetch, ack after 1 cycle:
  - `memread=1`, `irwrite=1`, `adr=0x10`, `mem_rdata=0x00500113` → `mem_req` high 1 cycle with `mem_addr=0x10`.
  - `instr=0x00500113`; `stall` high exactly 2 cycles; `data` unchanged.
- lw with 3-cycle ack delay:
  - `memread=1`, `irwrite=0`, `adr=0x60`, `mem_rdata=0xCAFEF00D` → `stall` high 4 cycles; `data=0xCAFEF00D`; `instr` unchanged.
  - `mem_addr` stable throughout.
- sw with simultaneous `memread=1`, `memwrite=1`, `adr=0x64`, `writedata=0x7` → `mem_we=1`, `mem_wdata=0x7`; no register update; one transaction only.
- Strobe still high in DONE → no second `mem_req`; the next transaction starts only after the strobe is reasserted in IDLE.
- Reset pulled low while BUSY → `mem_req`=0 immediately; `instr`=`data`=0.
  - A late `mem_ack` after release causes no update and `stall`=0.
- With `MEM_BUS_IF_TIMEOUT_EN`, `TIMEOUT_CYCLES=4`, never ack → `mem_req` drops after 4 BUSY cycles.
  - `err`=1 and stays high; `stall` releases in DONE.
